div_out_stage: RTL and testbench

DIV_OUT_STAGE -- requirements
Module: div_out_stage

---
 rtl/div_out_stage_if.sv | 35 +++
 rtl/div_out_stage.sv | 139 +++++++++++++
 tb/tb_div_out_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/div_out_stage_if.sv
// Result handshake between the final divider cell, the output FIFO and its consumer.
//   in_rdy        : final-stage result valid this cycle (no backpressure)
//   in_merchant   : final-stage quotient, N bits
//   in_remainder  : final-stage remainder, M bits
//   in_divisor    : divisor carried with the result, used for zero detection
//   out_valid     : FIFO head holds a result
//   out_ready     : consumer accepts the head this cycle
//   out_quot      : head quotient
//   out_rem       : head remainder
//   out_dz        : head result was a divide-by-zero
// slave modport is the FIFO side; master modport is the producer/consumer side.
interface div_out_stage_if #(
    parameter int unsigned N = 5,
    parameter int unsigned M = 3
);
    logic         in_rdy;
    logic [N-1:0] in_merchant;
    logic [M-1:0] in_remainder;
    logic [M-1:0] in_divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_quot;
    logic [M-1:0] out_rem;
    logic         out_dz;

    modport slave (
        input  in_rdy, in_merchant, in_remainder, in_divisor, out_ready,
        output out_valid, out_quot, out_rem, out_dz
    );

    modport master (
        output in_rdy, in_merchant, in_remainder, in_divisor, out_ready,
        input  out_valid, out_quot, out_rem, out_dz
    );
endinterface

// File: rtl/div_out_stage.sv
// Output stage of the divider: captures each final-stage result into a small
// FIFO, substituting a divide-by-zero marker when the divisor is zero, and
// tracks results lost to overflow.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : result handshake (slave side), see div_out_stage_if
//   ovf_clr  : clears ovf and drop_cnt (a same-cycle drop wins)
//   count    : current occupancy
//   full     : count == DEPTH
//   ovf      : sticky, a result was dropped
//   drop_cnt : saturating count of dropped results
module div_out_stage #(
    parameter int unsigned N     = 5,
    parameter int unsigned M     = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    div_out_stage_if.slave          bus,
    input  logic                    ovf_clr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    ovf,
    output logic [7:0]              drop_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [N-1:0]  quot_q [DEPTH];
    logic [N-1:0]  quot_d [DEPTH];
    logic [M-1:0]  rem_q  [DEPTH];
    logic [M-1:0]  rem_d  [DEPTH];
    logic          dz_q   [DEPTH];
    logic          dz_d   [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          dz_in;

    // Next-state: pointers, occupancy, storage write and overflow tracking.
    always_comb begin
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        pop     = valid_q && bus.out_ready;
        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
        push_ok = bus.in_rdy && ((count_q != CW'(DEPTH)) || pop);
        drop    = bus.in_rdy && !push_ok;
        dz_in   = (bus.in_divisor == '0);

        if (push_ok) begin
            quot_d[wptr_q] = dz_in ? '1 : bus.in_merchant;
            rem_d[wptr_q]  = dz_in ? '0 : bus.in_remainder;
            dz_d[wptr_q]   = dz_in;
            wptr_d         = wptr_q + PW'(1);
        end

        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end

        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end

        // Drop takes priority over a simultaneous clear.
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = 8'd0;
        end

        valid_d = (count_d != '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    // State registers; reset also zeroes storage so the head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                quot_q[i] <= '0;
                rem_q[i]  <= '0;
                dz_q[i]   <= 1'b0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_quot  = quot_q[rptr_q];
    assign bus.out_rem   = rem_q[rptr_q];
    assign bus.out_dz    = dz_q[rptr_q];
    assign count         = count_q;
    assign full          = full_q;
    assign ovf           = ovf_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_div_out_stage.sv
// Directed bench for div_out_stage with N=5, M=3, DEPTH=4.
module tb_div_out_stage;

    logic       clk;
    logic       rst;
    logic       ovf_clr;
    logic [2:0] count;
    logic       full;
    logic       ovf;
    logic [7:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    div_out_stage_if #(.N(5), .M(3)) bus ();

    div_out_stage #(.N(5), .M(3), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ovf_clr  (ovf_clr),
        .count    (count),
        .full     (full),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic [4:0] q, input logic [2:0] r,
                         input logic [2:0] d, input logic ordy);
        bus.in_rdy       = rdy;
        bus.in_merchant  = q;
        bus.in_remainder = r;
        bus.in_divisor   = d;
        bus.out_ready    = ordy;
    endtask

    initial begin
        rst     = 1'b1;
        ovf_clr = 1'b0;
        // Push attempt while in reset must be ignored.
        drive(1'b1, 5'd17, 3'd2, 3'd3, 1'b0);
        tick();
        chk("rst_count",  32'(count), 32'd0);
        chk("rst_valid",  32'(bus.out_valid), 32'd0);
        chk("rst_full",   32'(full), 32'd0);
        chk("rst_ovf",    32'(ovf), 32'd0);
        chk("rst_drop",   32'(drop_cnt), 32'd0);
        chk("rst_quot",   32'(bus.out_quot), 32'd0);
        chk("rst_rem",    32'(bus.out_rem), 32'd0);
        chk("rst_dz",     32'(bus.out_dz), 32'd0);
        rst = 1'b0;

        // Single result with consumer ready: visible next cycle, gone the one after.
        drive(1'b1, 5'd6, 3'd1, 3'd3, 1'b1);
        tick();
        chk("one_valid", 32'(bus.out_valid), 32'd1);
        chk("one_quot",  32'(bus.out_quot), 32'd6);
        chk("one_rem",   32'(bus.out_rem), 32'd1);
        chk("one_dz",    32'(bus.out_dz), 32'd0);
        drive(1'b0, 5'd0, 3'd0, 3'd3, 1'b1);
        tick();
        chk("one_popped_valid", 32'(bus.out_valid), 32'd0);
        chk("one_popped_count", 32'(count), 32'd0);

        // Divide-by-zero substitution.
        drive(1'b1, 5'd9, 3'd5, 3'd0, 1'b0);
        tick();
        chk("dz_quot",  32'(bus.out_quot), 32'd31);
        chk("dz_rem",   32'(bus.out_rem), 32'd0);
        chk("dz_flag",  32'(bus.out_dz), 32'd1);
        chk("dz_count", 32'(count), 32'd1);
        drive(1'b0, 5'd0, 3'd0, 3'd3, 1'b1);
        tick();
        chk("dz_drained", 32'(count), 32'd0);

        // Fill with 1..6, consumer stalled: two overflow drops.
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 5'(k), 3'(k), 3'd3, 1'b0);
            tick();
            if (k == 4) begin
                chk("fill4_full",  32'(full), 32'd1);
                chk("fill4_count", 32'(count), 32'd4);
                chk("fill4_ovf",   32'(ovf), 32'd0);
            end
        end
        chk("fill6_ovf",   32'(ovf), 32'd1);
        chk("fill6_drop",  32'(drop_cnt), 32'd2);
        chk("fill6_count", 32'(count), 32'd4);
        drive(1'b0, 5'd0, 3'd0, 3'd3, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain6_q%0d", k), 32'(bus.out_quot), 32'(k));
            chk($sformatf("drain6_r%0d", k), 32'(bus.out_rem), 32'(k));
            tick();
        end
        chk("drain6_valid", 32'(bus.out_valid), 32'd0);
        chk("drain6_full",  32'(full), 32'd0);

        // Clear overflow with no drop pending.
        drive(1'b0, 5'd0, 3'd0, 3'd3, 1'b0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_ovf",  32'(ovf), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);

        // Full FIFO with simultaneous push and pop: accepted, no drop.
        for (int k = 10; k <= 13; k++) begin
            drive(1'b1, 5'(k), 3'd0, 3'd3, 1'b0);
            tick();
        end
        chk("pp_full_before", 32'(full), 32'd1);
        drive(1'b1, 5'd14, 3'd6, 3'd3, 1'b1);
        tick();
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_ovf",   32'(ovf), 32'd0);
        chk("pp_drop",  32'(drop_cnt), 32'd0);
        drive(1'b0, 5'd0, 3'd0, 3'd3, 1'b1);
        for (int k = 11; k <= 14; k++) begin
            chk($sformatf("pp_drain_q%0d", k), 32'(bus.out_quot), 32'(k));
            tick();
        end
        chk("pp_drain_valid", 32'(bus.out_valid), 32'd0);

        // Drop coinciding with clear: drop wins and restarts the count at 1.
        for (int k = 20; k <= 24; k++) begin
            drive(1'b1, 5'(k), 3'd0, 3'd3, 1'b0);
            tick();
        end
        chk("prio_pre_drop", 32'(drop_cnt), 32'd1);
        drive(1'b1, 5'd25, 3'd0, 3'd3, 1'b0);
        ovf_clr = 1'b1;
        tick();
        chk("prio_ovf",  32'(ovf), 32'd1);
        chk("prio_drop", 32'(drop_cnt), 32'd1);
        drive(1'b0, 5'd0, 3'd0, 3'd3, 1'b0);
        tick();
        ovf_clr = 1'b0;
        chk("prio_clr_ovf",  32'(ovf), 32'd0);
        chk("prio_clr_drop", 32'(drop_cnt), 32'd0);
        chk("prio_head",     32'(bus.out_quot), 32'd20);

        // Saturation: 256 drops leave drop_cnt pinned at 255.
        drive(1'b1, 5'd30, 3'd0, 3'd3, 1'b0);
        for (int k = 0; k < 256; k++) tick();
        chk("sat_drop",  32'(drop_cnt), 32'd255);
        chk("sat_count", 32'(count), 32'd4);

        // Mid-cycle asynchronous reset with 3 entries stored.
        drive(1'b0, 5'd0, 3'd0, 3'd3, 1'b1);
        tick();
        drive(1'b0, 5'd0, 3'd0, 3'd3, 1'b0);
        chk("arst_pre_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_drop",  32'(drop_cnt), 32'd0);
        chk("arst_quot",  32'(bus.out_quot), 32'd0);
        rst = 1'b0;
        drive(1'b1, 5'd7, 3'd2, 3'd5, 1'b0);
        tick();
        drive(1'b0, 5'd0, 3'd0, 3'd3, 1'b0);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_quot",  32'(bus.out_quot), 32'd7);
        chk("post_rst_rem",   32'(bus.out_rem), 32'd2);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
